// File: rtl/instr_fetch_buffer_if.sv
// Decode-side handshake of the fetch buffer: head instruction, its byte address, valid/ready.
interface instr_fetch_buffer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] instr_addr;
    logic                  instr_valid;
    logic                  instr_ready;

    modport master (
        output instr,
        output instr_addr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_addr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: drives ROM address, captures 1-cycle-latency data into a small FIFO toward decode.
// First word valid 2 cycles after issue; issue stalls when buffered + in-flight words would overflow.
module instr_fetch_buffer #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [31:0]           rom_rdata_i,
    input  logic                  jmp_i,
    input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
    instr_fetch_buffer_if.master  dec_if
);
    localparam int                CW        = $clog2(FIFO_DEPTH);
    localparam logic [CW+1:0]     OCC_LIMIT = (CW+2)'(FIFO_DEPTH);
    localparam logic [CW:0]       CNT_MAX   = (CW+1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
    logic [CW:0]           count_q, count_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [31:0]           data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW+1:0] occ;

    assign rom_addr_o         = pc_q;
    assign dec_if.instr_valid = (count_q != '0);
    assign dec_if.instr       = data_q[rd_ptr_q];
    assign dec_if.instr_addr  = addr_q[rd_ptr_q];

    always_comb begin
        pop   = (count_q != '0) && dec_if.instr_ready;
        push  = inflight_q && !jmp_i;
        // Occupancy the FIFO will hold after this edge, counting the word returning now.
        occ   = {1'b0, count_q} + (CW+2)'(inflight_q) - (CW+2)'(pop);
        issue = !jmp_i && (occ < OCC_LIMIT);

        pc_d            = pc_q;
        inflight_d      = 1'b0;
        inflight_addr_d = inflight_addr_q;
        count_d         = count_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;

        if (jmp_i) begin
            pc_d     = jmp_addr_i & ~ADDR_WIDTH'(3);
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (issue) begin
                inflight_d      = 1'b1;
                inflight_addr_d = pc_q;
                pc_d            = pc_q + ADDR_WIDTH'(4);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + CW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + CW'(1);
            end
            count_d = count_q + (CW+1)'(push) - (CW+1)'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q            <= BOOT_ADDR;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            count_q         <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            count_q         <= count_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            if (push) begin
                data_q[wr_ptr_q] <= rom_rdata_i;
                addr_q[wr_ptr_q] <= inflight_addr_q;
            end
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) count_q <= CNT_MAX);

endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Instruction fetch stage sitting directly upstream of the single-port instruction ROM wrapper.
- Drives the ROM read address and captures the returned word after the ROM's fixed 1-cycle read latency.
- Buffers fetched words in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles jump redirects by flushing buffered and in-flight words.

Parameters:
- ADDR_WIDTH, 32, byte address width of PC and ROM address.
- BOOT_ADDR, 32'h0000_0000, PC value after reset; word aligned.
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, minimum 2.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- rom_addr_o  output  ADDR_WIDTH  byte address to ROM; connects to the ROM interface ram_addr.
- rom_rdata_i  input  32  ROM read data; connects to the ROM interface ram_rdata; valid the cycle after its address was presented.
- jmp_i  input  1  redirect request, single-cycle pulse or level.
- jmp_addr_i  input  ADDR_WIDTH  redirect target; bits [1:0] ignored and forced to 0.
- instr_o  output  32  instruction word at FIFO head.
- instr_addr_o  output  ADDR_WIDTH  byte address of instr_o.
- instr_valid_o  output  1  FIFO non-empty.
- instr_ready_i  input  1  decode accepts head word.

Behaviour:
- Reset (asynchronous, active-high):
  - pc = BOOT_ADDR, so rom_addr_o = BOOT_ADDR.
  - FIFO count = 0, inflight = 0.
  - instr_valid_o = 0; instr_o = 0; instr_addr_o = 0.
- rom_addr_o = pc, combinationally. The ROM samples it every edge; reads have no side effects.
- pop = instr_valid_o & instr_ready_i.
- issue = !jmp_i & ((count + inflight - pop) < FIFO_DEPTH).
- On issue:
  - inflight_q <= 1; inflight_addr_q <= pc.
  - pc <= pc + 4, wrapping modulo 2^ADDR_WIDTH (pc at all-ones-minus-3 wraps to 0).
- Without issue: inflight_q <= 0; pc holds.
- Push: when inflight_q = 1 and !jmp_i, write {rom_rdata_i, inflight_addr_q} to the FIFO tail.
- Overflow is impossible by the issue rule; an assertion checks count <= FIFO_DEPTH.
- Simultaneous push and pop: count unchanged. Push into an empty FIFO becomes visible the next cycle; there is no bypass.
- Head stability:
  - While instr_valid_o = 1 and instr_ready_i = 0, instr_o and instr_addr_o hold.
  - The only exception is jmp_i, which may drop valid.
- Throughput: 1 instruction/cycle sustained with instr_ready_i held high.
- Latency:
  - Reset release to first instr_valid_o: 2 cycles. Cycle 0 issues BOOT_ADDR; cycle 1 data returns; cycle 2 valid.
- Redirect (jmp_i = 1 in cycle N):
  - Highest priority over push, pop and issue.
  - At the edge: pc <= {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00}; count <= 0; inflight_q <= 0.
  - The ROM data returning in cycle N is discarded.
  - The pop in cycle N is not a valid transfer; decode must ignore it.
  - Cycle N+1 issues the target; target word is valid in cycle N+3.
  - Back-to-back jmp_i: the last one wins; no issue occurs while jmp_i is high.
- Reset asserted mid-operation: immediate return to reset state; in-flight data discarded.
- Unused head storage contents are don't-care, but outputs must be X-free after reset.

Test Plan:
- Reset release, ROM word[i] = 0x1000_0000 + i, ready held high: valid first in cycle 2, then instr_o/instr_addr_o = 0x1000_0000/0x0, 0x1000_0001/0x4, 0x1000_0002/0x8 on consecutive cycles, with no bubbles.
- Backpressure: ready low from cycle 3 for 5 cycles.
  - count saturates at 2 and pc stops advancing.
  - instr_o stays stable at addr 0x4.
  - After ready returns high: addresses 0x4, 0x8, 0xC in order, none lost or duplicated.
- Redirect: jmp_i pulse with jmp_addr_i = 0x43 in steady streaming.
  - valid drops the next cycle.
  - First valid 3 cycles after the pulse, with instr_addr_o = 0x40 and instr_o = word[0x10].
  - No stale pre-jump word appears.
- Jump while stalled and full (ready low, count = 2), jmp_addr_i = 0x100: buffer flushed; after ready rises, the stream restarts at 0x100.
- Wrap-around: ADDR_WIDTH = 8, jmp to 0xF8, ready high: addresses 0xF8, 0xFC, 0x00, 0x04.
- Asynchronous reset asserted mid-stream between edges: valid = 0 and rom_addr_o = BOOT_ADDR immediately; after release, the stream restarts at BOOT_ADDR.
